// File: rtl/systolic_job_scheduler_pkg.sv
// Shared types for the systolic job scheduler: FSM states, the job descriptor
// and the legality rule for a job's matrix dimension.
package systolic_job_scheduler_pkg;

    localparam int JOB_AW = 12;
    localparam int JOB_NW = 4;

    typedef enum logic [1:0] {
        SCHED_IDLE      = 2'd0,
        SCHED_LAUNCH    = 2'd1,
        SCHED_WAIT_DONE = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [JOB_AW-1:0] addr_a;
        logic [JOB_AW-1:0] addr_b;
        logic [JOB_AW-1:0] addr_c;
        logic [JOB_NW-1:0] n;
    } job_desc_t;

    // A job is runnable only if its dimension fits the array (1..max_n).
    function automatic logic job_n_legal(input logic [JOB_NW-1:0] n, input int max_n);
        return (n != 4'd0) && (int'(n) <= max_n);
    endfunction

endpackage

// File: rtl/systolic_job_scheduler_if.sv
// Host job-descriptor handshake plus the SystolicController launch/done signals.
// master = host/controller side, slave = scheduler.
interface systolic_job_scheduler_if #(
    parameter int AW = 12
) ();

    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_addr_a;
    logic [AW-1:0] job_addr_b;
    logic [AW-1:0] job_addr_c;
    logic [3:0]    job_n;

    logic          ctrl_new_data;
    logic [AW-1:0] ctrl_addr_a;
    logic [AW-1:0] ctrl_addr_b;
    logic [AW-1:0] ctrl_addr_c;
    logic [3:0]    ctrl_n;
    logic          ctrl_done;

    modport master (
        output job_valid, job_addr_a, job_addr_b, job_addr_c, job_n, ctrl_done,
        input  job_ready, ctrl_new_data, ctrl_addr_a, ctrl_addr_b, ctrl_addr_c, ctrl_n
    );

    modport slave (
        input  job_valid, job_addr_a, job_addr_b, job_addr_c, job_n, ctrl_done,
        output job_ready, ctrl_new_data, ctrl_addr_a, ctrl_addr_b, ctrl_addr_c, ctrl_n
    );

endinterface

// File: rtl/systolic_job_scheduler_job_fifo.sv
// job_fifo: synchronous FIFO of job descriptors with registered full and a count.
module job_fifo
    import systolic_job_scheduler_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  job_desc_t     wr_data,
    output job_desc_t     rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    job_desc_t     mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          full_r;
    logic          push_s;
    logic          pop_s;

    assign push_s  = push && !full_r;
    assign pop_s   = pop && (count_r != CW'(0));
    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = (count_r == CW'(0));
    assign count   = count_r;

    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // full resets high so the host sees no ready while reset is applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            full_r   <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/systolic_job_scheduler.sv
// Queues matrix-multiply jobs and launches them one at a time on SystolicController.
// Define JOB_TIMEOUT_EN to add a done-watchdog and the sticky err_timeout output.
module systolic_job_scheduler
    import systolic_job_scheduler_pkg::*;
#(
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int AW      = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    systolic_job_scheduler_if.slave  bus,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              jobs_completed,
    output logic                     err_invalid
`ifdef JOB_TIMEOUT_EN
    ,
    output logic                     err_timeout
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || N < 1) begin : g_bad_params
        $error("systolic_job_scheduler: illegal DEPTH/TIMEOUT/N");
    end

    sched_state_t          state_r, state_next_s;
    job_desc_t             wr_s, head_s;
    logic                  empty_s, full_s;
    logic [$clog2(DEPTH):0] count_s;
    logic                  pop_s, load_s, bad_s, done_s;
    logic                  fetched_r, new_data_r, busy_r, err_inv_r;
    logic [AW-1:0]         ctrl_a_r, ctrl_b_r, ctrl_c_r;
    logic [3:0]            ctrl_n_r;
    logic [15:0]           jobs_r;

    assign wr_s = '{addr_a: JOB_AW'(bus.job_addr_a), addr_b: JOB_AW'(bus.job_addr_b),
                    addr_c: JOB_AW'(bus.job_addr_c), n: bus.job_n};

    job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.job_valid),
        .pop     (pop_s),
        .wr_data (wr_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    assign bus.job_ready     = !full_s;
    assign bus.ctrl_new_data = new_data_r;
    assign bus.ctrl_addr_a   = ctrl_a_r;
    assign bus.ctrl_addr_b   = ctrl_b_r;
    assign bus.ctrl_addr_c   = ctrl_c_r;
    assign bus.ctrl_n        = ctrl_n_r;
    assign busy              = busy_r;
    assign fifo_count        = count_s;
    assign jobs_completed    = jobs_r;
    assign err_invalid       = err_inv_r;

`ifdef JOB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_r;
    logic          tmo_s, err_tmo_r;

    assign err_timeout = err_tmo_r;

    // Watchdog: counts WAIT_DONE cycles, cleared whenever another state is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= TW'(0);
            err_tmo_r <= 1'b0;
        end else begin
            tmo_cnt_r <= (state_r == SCHED_WAIT_DONE) ? tmo_cnt_r + TW'(1) : TW'(0);
            err_tmo_r <= err_tmo_r | tmo_s;
        end
    end
`endif

    // IDLE pops in one cycle (fetched_r) and moves to LAUNCH on the next, so the
    // operands are already stable when new_data rises.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        bad_s        = 1'b0;
        done_s       = 1'b0;
`ifdef JOB_TIMEOUT_EN
        tmo_s        = 1'b0;
`endif
        case (state_r)
            SCHED_IDLE: begin
                if (fetched_r) begin
                    state_next_s = SCHED_LAUNCH;
                end else if (!empty_s) begin
                    pop_s = 1'b1;
                    if (job_n_legal(head_s.n, N)) begin
                        load_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                end else begin
                    state_next_s = SCHED_IDLE;
                end
            end
            SCHED_LAUNCH: state_next_s = SCHED_WAIT_DONE;
            SCHED_WAIT_DONE: begin
                if (bus.ctrl_done) begin
                    done_s       = 1'b1;
                    state_next_s = SCHED_IDLE;
                end
`ifdef JOB_TIMEOUT_EN
                else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
                    tmo_s        = 1'b1;
                    state_next_s = SCHED_IDLE;
                end
`endif
                else begin
                    state_next_s = SCHED_WAIT_DONE;
                end
            end
            default: state_next_s = SCHED_IDLE;
        endcase
    end

    // State, launch operands and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= SCHED_IDLE;
            fetched_r  <= 1'b0;
            new_data_r <= 1'b0;
            busy_r     <= 1'b0;
            err_inv_r  <= 1'b0;
            jobs_r     <= 16'd0;
            ctrl_a_r   <= AW'(0);
            ctrl_b_r   <= AW'(0);
            ctrl_c_r   <= AW'(0);
            ctrl_n_r   <= 4'd0;
        end else begin
            state_r    <= state_next_s;
            fetched_r  <= load_s;
            new_data_r <= (state_next_s == SCHED_LAUNCH);
            busy_r     <= (state_next_s != SCHED_IDLE);
            err_inv_r  <= err_inv_r | bad_s;
            jobs_r     <= jobs_r + {15'd0, done_s};
            if (load_s) begin
                ctrl_a_r <= AW'(head_s.addr_a);
                ctrl_b_r <= AW'(head_s.addr_b);
                ctrl_c_r <= AW'(head_s.addr_c);
                ctrl_n_r <= head_s.n;
            end
        end
    end

endmodule
